// File: rtl/utim64_main_ctrl.sv
// utim64 bus controller: 64-bit main counter with prescaler, register
// decode into per-channel comparator strobes, sticky IRQ pending/mask.
// Ports: iCLOCK/inRESET; bus iBUS_REQ/RW/ADDR/DATA -> oBUS_BUSY/VALID/DATA;
// oMTIMER_*: main counter; oCONF_*/oCOUNT_*/onCOUNT_DQM: channel strobes;
// iCMP_IRQ -> oIRQ. Macro UTIM64_CNT_READBACK_EN enables COUNT readback.
module utim64_main_ctrl #(
  parameter int NCMP = 4
) (
  input  logic            iCLOCK,
  input  logic            inRESET,
  input  logic            iBUS_REQ,
  output logic            oBUS_BUSY,
  input  logic            iBUS_RW,
  input  logic [5:0]      iBUS_ADDR,
  input  logic [31:0]     iBUS_DATA,
  output logic            oBUS_VALID,
  output logic [31:0]     oBUS_DATA,
  output logic            oMTIMER_WORKING,
  output logic [63:0]     oMTIMER_COUNT,
  output logic [NCMP-1:0] oCONF_WRITE,
  output logic            oCONF_ENA,
  output logic            oCONF_IRQENA,
  output logic            oCONF_64MODE,
  output logic            oCONF_PERIODIC,
  output logic [NCMP-1:0] oCOUNT_WRITE,
  output logic [1:0]      onCOUNT_DQM,
  output logic [63:0]     oCOUNT_COUNTER,
  input  logic [NCMP-1:0] iCMP_IRQ,
  output logic            oIRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2
  } state_t;

  state_t state, stateNext;

  logic accept, wrAcc, rdAcc;
  assign accept = iBUS_REQ && (state == IDLE);
  assign wrAcc  = accept && iBUS_RW;
  assign rdAcc  = accept && !iBUS_RW;

  logic wrMctrl, wrMcL, wrMcH, wrPend, wrMask;
  assign wrMctrl = wrAcc && (iBUS_ADDR == 6'h00);
  assign wrMcL   = wrAcc && (iBUS_ADDR == 6'h01);
  assign wrMcH   = wrAcc && (iBUS_ADDR == 6'h02);
  assign wrPend  = wrAcc && (iBUS_ADDR == 6'h03);
  assign wrMask  = wrAcc && (iBUS_ADDR == 6'h04);

  // Channel window 0x08..0x1F: index = addr[4:2]-2, sub-register = addr[1:0]
  logic       chArea;
  logic [2:0] chIdx;
  logic [1:0] chSub;
  assign chArea = !iBUS_ADDR[5] && (iBUS_ADDR[4:3] != 2'b00);
  assign chIdx  = iBUS_ADDR[4:2] - 3'd2;
  assign chSub  = iBUS_ADDR[1:0];

  logic [NCMP-1:0] chHit;
  always_comb begin
    chHit = '0;
    for (int i = 0; i < NCMP; i++)
      chHit[i] = chArea && (chIdx == 3'(i));
  end

  logic [NCMP-1:0] wrConf, wrCntL, wrCntH;
  assign wrConf = (wrAcc && chSub == 2'd0) ? chHit : '0;
  assign wrCntL = (wrAcc && chSub == 2'd1) ? chHit : '0;
  assign wrCntH = (wrAcc && chSub == 2'd2) ? chHit : '0;

  logic            ena;
  logic [7:0]      prescale, preCnt;
  logic [63:0]     mCount;
  logic [31:0]     mShadow;
  logic [NCMP-1:0] pending, irqMask;
  logic            irqReg;
  logic [3:0]      confBits;
  logic [NCMP-1:0] confWr, cntWr;
  logic [1:0]      dqm;
  logic [63:0]     cntData;
  logic [31:0]     rdMux, rdData;
  logic [3:0]      confSh [NCMP];
`ifdef UTIM64_CNT_READBACK_EN
  logic [63:0]     cntSh [NCMP];
`endif

  always_comb begin
    rdMux = '0;
    case (iBUS_ADDR)
      6'h00:   rdMux = {16'h0, prescale, 6'h0, 1'b0, ena};
      6'h01:   rdMux = mCount[31:0];
      6'h02:   rdMux = mShadow;
      6'h03:   rdMux = 32'(pending);
      6'h04:   rdMux = 32'(irqMask);
      default: ;
    endcase
    for (int i = 0; i < NCMP; i++) begin
      if (chHit[i]) begin
        case (chSub)
          2'd0:    rdMux = {28'h0, confSh[i]};
`ifdef UTIM64_CNT_READBACK_EN
          2'd1:    rdMux = cntSh[i][31:0];
          2'd2:    rdMux = cntSh[i][63:32];
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (rdAcc) stateNext = RD1;
      RD1:     stateNext = RD2;
      RD2:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    oBUS_BUSY  = (state != IDLE);
    oBUS_VALID = (state == RD2);
    oBUS_DATA  = (state == RD2) ? rdData : '0;
  end

  // CLR beats increment; MCOUNT loads only while stopped
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      mCount <= '0;
      preCnt <= '0;
    end else if (wrMctrl && iBUS_DATA[1]) begin
      mCount <= '0;
      preCnt <= '0;
    end else if (ena) begin
      if (preCnt == prescale) begin
        preCnt <= '0;
        mCount <= mCount + 64'd1;
      end else begin
        preCnt <= preCnt + 8'd1;
      end
    end else if (wrMcL) begin
      mCount[31:0] <= iBUS_DATA;
    end else if (wrMcH) begin
      mCount[63:32] <= iBUS_DATA;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ena      <= 1'b0;
      prescale <= '0;
      mShadow  <= '0;
      rdData   <= '0;
      irqMask  <= '0;
      pending  <= '0;
      irqReg   <= 1'b0;
      confWr   <= '0;
      cntWr    <= '0;
      dqm      <= 2'b11;
      confBits <= '0;
      cntData  <= '0;
    end else begin
      if (wrMctrl) begin
        ena      <= iBUS_DATA[0];
        prescale <= iBUS_DATA[15:8];
      end
      if (rdAcc) rdData <= rdMux;
      // High half captured with the low-half read for coherent 64-bit reads
      if (rdAcc && iBUS_ADDR == 6'h01) mShadow <= mCount[63:32];
      if (wrMask) irqMask <= iBUS_DATA[NCMP-1:0];
      pending <= (pending & ~(wrPend ? iBUS_DATA[NCMP-1:0] : '0))
               | iCMP_IRQ;
      irqReg <= |(pending & irqMask);
      confWr <= wrConf;
      cntWr  <= wrCntL | wrCntH;
      dqm    <= (|wrCntL) ? 2'b10 :
                (|wrCntH) ? 2'b01 : 2'b11;
      if (|wrConf) confBits <= iBUS_DATA[3:0];
      if (|(wrCntL | wrCntH)) cntData <= {iBUS_DATA, iBUS_DATA};
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < NCMP; i++) begin
        confSh[i] <= '0;
`ifdef UTIM64_CNT_READBACK_EN
        cntSh[i]  <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NCMP; i++) begin
        if (wrConf[i]) confSh[i] <= iBUS_DATA[3:0];
`ifdef UTIM64_CNT_READBACK_EN
        if (wrCntL[i]) cntSh[i][31:0]  <= iBUS_DATA;
        if (wrCntH[i]) cntSh[i][63:32] <= iBUS_DATA;
`endif
      end
    end
  end

  assign oMTIMER_WORKING = ena;
  assign oMTIMER_COUNT   = mCount;
  assign oCONF_WRITE     = confWr;
  assign oCONF_ENA       = confBits[0];
  assign oCONF_IRQENA    = confBits[1];
  assign oCONF_64MODE    = confBits[2];
  assign oCONF_PERIODIC  = confBits[3];
  assign oCOUNT_WRITE    = cntWr;
  assign onCOUNT_DQM     = dqm;
  assign oCOUNT_COUNTER  = cntData;
  assign oIRQ            = irqReg;

endmodule

// File: doc/utim64_main_ctrl.md
Name: utim64_main_ctrl

Overview:
- Bus-side controller and main counter for the utim64 64-bit timer.
- Owns the free-running 64-bit main counter and its prescaler.
- Decodes 32-bit register bus accesses into the configuration-write and counter-write strobes that drive NCMP comparator channels.
- Collects the channels' IRQ lines into a sticky pending register and drives one summary interrupt.

Parameters:
- NCMP, 4, number of comparator channels served (1..4).

Ports:
- iCLOCK  in  1  system clock
- inRESET  in  1  asynchronous active-low reset
- iBUS_REQ  in  1  access request
- oBUS_BUSY  out  1  request not accepted this cycle
- iBUS_RW  in  1  1=write, 0=read
- iBUS_ADDR  in  6  word address
- iBUS_DATA  in  32  write data
- oBUS_VALID  out  1  read data valid (1-cycle pulse)
- oBUS_DATA  out  32  read data
- oMTIMER_WORKING  out  1  main counter enabled
- oMTIMER_COUNT  out  64  main counter value
- oCONF_WRITE  out  NCMP  per-channel configuration write strobe
- oCONF_ENA / oCONF_IRQENA / oCONF_64MODE / oCONF_PERIODIC  out  1 each  shared configuration bits
- oCOUNT_WRITE  out  NCMP  per-channel counter write strobe
- onCOUNT_DQM  out  2  active-low half mask; bit0 = [31:0], bit1 = [63:32]
- oCOUNT_COUNTER  out  64  counter write data, 32-bit word replicated in both halves
- iCMP_IRQ  in  NCMP  comparator interrupt lines (level)
- oIRQ  out  1  OR of pending & mask

Behaviour:
- Reset: all registers 0 and all outputs 0, except onCOUNT_DQM = 2'b11.
- Register map (word addresses):
  - 0x00 MCTRL: bit0 ENA, bit1 CLR (write-only, self-clearing), bits[15:8] PRESCALE.
  - 0x01 MCOUNT_L, 0x02 MCOUNT_H.
  - 0x03 IRQ_PEND: read status; write 1 clears the bit.
  - 0x04 IRQ_MASK.
  - Channel k at 0x08+4k: CONF (bits 0 ENA, 1 IRQENA, 2 64MODE, 3 PERIODIC), 0x09+4k COUNT_L, 0x0A+4k COUNT_H.
  - Unmapped addresses, or channel k ≥ NCMP: writes ignored, reads return 0.
- Handshake:
  - A request is accepted when iBUS_REQ=1 and oBUS_BUSY=0.
  - Write: takes effect at the next edge; oBUS_BUSY stays 0.
  - Read: FSM IDLE→RD1→RD2→IDLE. oBUS_BUSY=1 in RD1 and RD2. oBUS_VALID=1 with data in RD2 (latency 2). A request in RD1/RD2 is not accepted.
  - Reset mid-read: FSM returns to IDLE; no VALID is produced.
- Main counter:
  - When ENA=1, a prescale counter runs 0..PRESCALE; on reaching PRESCALE it returns to 0 and the main counter increments by 1.
  - PRESCALE=0 means increment every cycle.
  - The main counter wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
  - CLR zeroes the main counter and prescale counter at the next edge, and takes priority over an increment in the same cycle.
  - Writes to MCOUNT_L/H load the corresponding half only when ENA=0; they are ignored while ENA=1.
  - oMTIMER_WORKING = ENA.
- 64-bit read coherency:
  - Reading MCOUNT_L returns the low half and snapshots the high half (from the same cycle) into a shadow register.
  - Reading MCOUNT_H returns the shadow.
- Channel writes, all strobes one cycle wide, registered, asserted the cycle after acceptance:
  - CONF write: oCONF_WRITE[k]=1, with oCONF_* = iBUS_DATA[3:0].
  - COUNT_L write: oCOUNT_WRITE[k]=1, onCOUNT_DQM=2'b10.
  - COUNT_H write: oCOUNT_WRITE[k]=1, onCOUNT_DQM=2'b01.
  - oCOUNT_COUNTER = {data, data}.
  - When no strobe is active, onCOUNT_DQM returns to 2'b11.
- Channel shadow registers: CONF and COUNT shadows are kept per channel for readback.
- Interrupt:
  - pending[k] is set when iCMP_IRQ[k]=1.
  - pending[k] is cleared by writing 1 to IRQ_PEND bit k.
  - Set wins over a simultaneous clear.
  - oIRQ is registered: |(pending & IRQ_MASK), one cycle after pending changes.

Optional Feature:
- Macro UTIM64_CNT_READBACK_EN.
- Defined: COUNT_L/COUNT_H reads return the per-channel shadow of the last written counter value.
- Not defined: the COUNT shadows are not implemented and COUNT reads return 0. CONF readback is unaffected.

Test Plan:
- Reset → write MCTRL=0x0000_0301 (PRESCALE=3, ENA=1) → oMTIMER_COUNT increments once every 4 cycles; read MCOUNT_L gives VALID exactly 2 cycles after acceptance, with BUSY high for both cycles.
- ENA=0, write MCOUNT_L=0xFFFF_FFFF and MCOUNT_H=0xFFFF_FFFF, set ENA with PRESCALE=0 → counter wraps to 0 on the second edge after ENA; a write to MCOUNT_L with ENA=1 leaves the count unchanged.
- Counter = 0x1_FFFF_FFFF: read MCOUNT_L, let the counter carry, then read MCOUNT_H → returns 0x1 (shadow value), not 0x2.
- Write 0x0A (channel 0 COUNT_H) = 0x1234_5678 → next cycle oCOUNT_WRITE=4'b0001, onCOUNT_DQM=2'b01, oCOUNT_COUNTER=0x1234_5678_1234_5678; then DQM returns to 2'b11. Write 0x0C (channel 1 CONF) = 0xF → oCONF_WRITE=4'b0010 with all four conf bits set.
- IRQ_MASK=0x1, pulse iCMP_IRQ[0] → oIRQ=1 one cycle later and stays set; W1C in the same cycle as a new iCMP_IRQ[0] → pending stays 1; a later W1C alone → oIRQ=0.
- Assert inRESET while the FSM is in RD1 → no oBUS_VALID pulse, all outputs at reset values; the next read after reset release works normally.
